sample_fifo: RTL and testbench

Synchronous capture buffer that sits directly downstream of `sample_logic`. It stores the samples that `sample_logic` qualifies with its write enable. It returns `fifo_empty` and `fifo_full` status to `sample_logic`, and readout logic drains it one word per request. It adds fill-level reporting, sticky overflow/underflow error flags and a synchronous flush, so a capture can be aborted and restarted without a reset.

---
 rtl/sample_fifo.sv | 67 ++++++
 tb/tb_sample_fifo.sv | 90 +++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// sample_fifo: capture buffer with fill level, sticky error flags and synchronous flush
module sample_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 w_en_i,
  input  logic [DATA_SIZE-1:0] w_data_i,
  input  logic                 r_en_i,
  output logic [DATA_SIZE-1:0] r_data_o,
  output logic                 r_valid_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  input  logic                 err_clr_i
);
  localparam int P = ADDR_SIZE + 1;
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
  logic [P-1:0] wptr, rptr, wnxt, rnxt, lnxt;
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = w_en_i && !full_o;
    rd_ok = r_en_i && !empty_o;
    wnxt = wptr + P'(wr_ok);
    rnxt = rptr + P'(rd_ok);
    lnxt = wnxt - rnxt;
  end
  always_ff @(posedge clk_i)
    if (!rst_i && !clear_i && wr_ok) mem[wptr[ADDR_SIZE-1:0]] <= w_data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      level_o <= '0;
      empty_o <= 1'b1;
      full_o <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o <= '0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      wptr <= '0;
      rptr <= '0;
      level_o <= '0;
      empty_o <= 1'b1;
      full_o <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o <= '0;
      overflow_o <= overflow_o && !err_clr_i;
      underflow_o <= underflow_o && !err_clr_i;
    end else begin
      wptr <= wnxt;
      rptr <= rnxt;
      level_o <= lnxt;
      empty_o <= lnxt == '0;
      full_o <= lnxt[ADDR_SIZE];
      r_valid_o <= rd_ok;
      if (rd_ok) r_data_o <= mem[rptr[ADDR_SIZE-1:0]];
      overflow_o <= (w_en_i && full_o) || (overflow_o && !err_clr_i);
      underflow_o <= (r_en_i && empty_o) || (underflow_o && !err_clr_i);
    end
  end
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed and random checks of sample_fifo against a queue model
module tb_sample_fifo;
  logic clk = 0, rst = 0, clear = 0, w_en = 0, r_en = 0, err_clr = 0;
  logic [7:0] w_data = 0, r_data;
  logic r_valid, empty, full, overflow, underflow;
  logic [3:0] level;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] m_rdata = 0;
  logic m_rvalid = 0, m_ov = 0, m_un = 0;

  sample_fifo #(.DATA_SIZE(8), .ADDR_SIZE(3)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .w_en_i(w_en), .w_data_i(w_data),
    .r_en_i(r_en), .r_data_o(r_data), .r_valid_o(r_valid), .empty_o(empty),
    .full_o(full), .level_o(level), .overflow_o(overflow), .underflow_o(underflow),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_st, input logic clr, input logic w, input logic [7:0] wd,
                      input logic r, input logic ec);
    logic was_full, was_empty;
    rst = r_st; clear = clr; w_en = w; w_data = wd; r_en = r; err_clr = ec;
    @(posedge clk);
    #1;
    was_full = q.size() == 8;
    was_empty = q.size() == 0;
    if (r_st) begin
      q.delete(); m_rdata = 0; m_rvalid = 0; m_ov = 0; m_un = 0;
    end else if (clr) begin
      q.delete(); m_rdata = 0; m_rvalid = 0;
      if (ec) begin m_ov = 0; m_un = 0; end
    end else begin
      if (ec) begin m_ov = 0; m_un = 0; end
      m_rvalid = 0;
      if (r && !was_empty) begin m_rdata = q.pop_front(); m_rvalid = 1; end
      else if (r) m_un = 1;
      if (w && !was_full) q.push_back(wd);
      else if (w) m_ov = 1;
    end
    check("empty", int'(empty), int'(q.size() == 0));
    check("full", int'(full), int'(q.size() == 8));
    check("level", int'(level), q.size());
    check("r_valid", int'(r_valid), int'(m_rvalid));
    check("r_data", int'(r_data), int'(m_rdata));
    check("overflow", int'(overflow), int'(m_ov));
    check("underflow", int'(underflow), int'(m_un));
  endtask

  initial begin
    step(1, 0, 1, 8'h55, 1, 0);
    step(1, 0, 1, 8'h66, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(i), 0, 0);
    step(0, 0, 1, 8'hAA, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h30 + i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i), 0, 1);
    step(0, 0, 1, 8'hBB, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 8'hCC, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h50 + i), 0, 0);
    step(0, 1, 1, 8'hDD, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h60 + i), 0, 0);
    step(1, 0, 1, 8'h77, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
